multi_delta_counter: RTL and testbench

Bank of NUM_CNT independent up/down counters, each with a per-cycle variable delta. Each channel selects wrap or saturate mode, keeps a sticky overflow/underflow flag and raises a registered compare-hit pulse. Used by timers, performance monitors and credit trackers that need several counters sharing one clock/reset domain.

---
 rtl/multi_delta_counter_pkg.sv | 17 +
 rtl/delta_counter_chan.sv | 75 +++++++
 rtl/multi_delta_counter.sv | 69 ++++++
 tb/tb_multi_delta_counter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_delta_counter_pkg.sv
// Shared types and defaults for the multi_delta_counter bank.
package multi_delta_counter_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  typedef struct packed {
    logic ovf;
    logic udf;
    logic hit;
  } cnt_status_t;

endpackage

// File: rtl/delta_counter_chan.sv
// One counter channel: variable-step up/down count, wrap/saturate, sticky flags and registered compare hit.
module delta_counter_chan
  import multi_delta_counter_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic             down,
  input  cnt_mode_e        mode,
  input  logic             flag_clr,
  input  logic [WIDTH-1:0] delta,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] cmp,
  output logic [WIDTH-1:0] q,
  output cnt_status_t      status
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_nxt;
  cnt_status_t      status_nxt;

  always_comb begin
    sum            = {1'b0, q} + {1'b0, delta};
    diff           = {1'b0, q} - {1'b0, delta};
    q_nxt          = q;
    // a fresh overflow/underflow below overrides a same-cycle flag clear
    status_nxt.ovf = status.ovf & ~flag_clr;
    status_nxt.udf = status.udf & ~flag_clr;
    status_nxt.hit = 1'b0;
    if (clear) begin
      q_nxt          = RST_VAL;
      status_nxt.ovf = 1'b0;
      status_nxt.udf = 1'b0;
    end else if (load) begin
      q_nxt          = d;
      status_nxt.ovf = 1'b0;
      status_nxt.udf = 1'b0;
      status_nxt.hit = (d == cmp);
    end else if (en) begin
      if (down) begin
        if (diff[WIDTH]) begin
          status_nxt.udf = 1'b1;
          q_nxt          = (mode == CNT_SAT) ? '0 : diff[WIDTH-1:0];
        end else begin
          q_nxt = diff[WIDTH-1:0];
        end
      end else begin
        if (sum[WIDTH]) begin
          status_nxt.ovf = 1'b1;
          q_nxt          = (mode == CNT_SAT) ? '1 : sum[WIDTH-1:0];
        end else begin
          q_nxt = sum[WIDTH-1:0];
        end
      end
      status_nxt.hit = (q_nxt == cmp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= RST_VAL;
      status <= '0;
    end else begin
      q      <= q_nxt;
      status <= status_nxt;
    end
  end

endmodule

// File: rtl/multi_delta_counter.sv
// Bank of NUM_CNT independent delta counters sharing one clock and reset.
// Optional atomic snapshot of all channels when MULTI_DELTA_COUNTER_SNAPSHOT_EN is defined.
module multi_delta_counter
  import multi_delta_counter_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter int               NUM_CNT = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
`ifdef MULTI_DELTA_COUNTER_SNAPSHOT_EN
  input  logic                            snap_i,
  output logic [NUM_CNT-1:0][WIDTH-1:0]   snap_o,
`endif
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_CNT-1:0]              clear_i,
  input  logic [NUM_CNT-1:0]              load_i,
  input  logic [NUM_CNT-1:0]              en_i,
  input  logic [NUM_CNT-1:0]              down_i,
  input  logic [NUM_CNT-1:0]              sat_i,
  input  logic [NUM_CNT-1:0][WIDTH-1:0]   delta_i,
  input  logic [NUM_CNT-1:0][WIDTH-1:0]   d_i,
  input  logic [NUM_CNT-1:0][WIDTH-1:0]   cmp_i,
  input  logic [NUM_CNT-1:0]              flag_clr_i,
  output logic [NUM_CNT-1:0][WIDTH-1:0]   q_o,
  output logic [NUM_CNT-1:0]              ovf_o,
  output logic [NUM_CNT-1:0]              udf_o,
  output logic [NUM_CNT-1:0]              hit_o
);

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_chan
    cnt_status_t status;

    delta_counter_chan #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL)
    ) u_chan (
      .clk     (clk_i),
      .rst     (rst_i),
      .clear   (clear_i[g]),
      .load    (load_i[g]),
      .en      (en_i[g]),
      .down    (down_i[g]),
      .mode    (cnt_mode_e'(sat_i[g])),
      .flag_clr(flag_clr_i[g]),
      .delta   (delta_i[g]),
      .d       (d_i[g]),
      .cmp     (cmp_i[g]),
      .q       (q_o[g]),
      .status  (status)
    );

    assign ovf_o[g] = status.ovf;
    assign udf_o[g] = status.udf;
    assign hit_o[g] = status.hit;
  end

`ifdef MULTI_DELTA_COUNTER_SNAPSHOT_EN
  // q_o here is the pre-update value, so a same-edge clear is not seen
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_o <= {NUM_CNT{RST_VAL}};
    end else if (snap_i) begin
      snap_o <= q_o;
    end
  end
`endif

endmodule

// File: tb/tb_multi_delta_counter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic against an arithmetic model.
module tb_multi_delta_counter;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int MAXV = (1 << W) - 1;
  localparam logic [W-1:0] RSTV = 8'h00;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [N-1:0] clear_i, load_i, en_i, down_i, sat_i, flag_clr_i;
  logic [N-1:0][W-1:0] delta_i, d_i, cmp_i;
  logic [N-1:0][W-1:0] q_o;
  logic [N-1:0] ovf_o, udf_o, hit_o;
`ifdef MULTI_DELTA_COUNTER_SNAPSHOT_EN
  logic snap_i;
  logic [N-1:0][W-1:0] snap_o;
  int m_snap [N];
`endif

  int m_q [N];
  bit m_ovf [N];
  bit m_udf [N];
  bit m_hit [N];
  bit started = 0;
  int checks = 0;
  int failures = 0;

  multi_delta_counter #(.WIDTH(W), .NUM_CNT(N), .RST_VAL(RSTV)) dut (
`ifdef MULTI_DELTA_COUNTER_SNAPSHOT_EN
    .snap_i    (snap_i),
    .snap_o    (snap_o),
`endif
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .load_i    (load_i),
    .en_i      (en_i),
    .down_i    (down_i),
    .sat_i     (sat_i),
    .delta_i   (delta_i),
    .d_i       (d_i),
    .cmp_i     (cmp_i),
    .flag_clr_i(flag_clr_i),
    .q_o       (q_o),
    .ovf_o     (ovf_o),
    .udf_o     (udf_o),
    .hit_o     (hit_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: plain integer arithmetic on the sampled inputs.
  always @(posedge clk_i) begin : model
    int s;
`ifdef MULTI_DELTA_COUNTER_SNAPSHOT_EN
    if (rst_i) begin
      for (int i = 0; i < N; i++) m_snap[i] = int'(RSTV);
    end else if (snap_i) begin
      for (int i = 0; i < N; i++) m_snap[i] = m_q[i];
    end
`endif
    for (int i = 0; i < N; i++) begin
      if (rst_i || clear_i[i]) begin
        m_q[i] = int'(RSTV); m_ovf[i] = 0; m_udf[i] = 0; m_hit[i] = 0;
      end else if (load_i[i]) begin
        m_q[i] = int'(d_i[i]); m_ovf[i] = 0; m_udf[i] = 0;
        m_hit[i] = (d_i[i] == cmp_i[i]);
      end else begin
        if (flag_clr_i[i]) begin m_ovf[i] = 0; m_udf[i] = 0; end
        m_hit[i] = 0;
        if (en_i[i]) begin
          s = down_i[i] ? m_q[i] - int'(delta_i[i]) : m_q[i] + int'(delta_i[i]);
          if (s > MAXV) begin
            m_ovf[i] = 1; m_q[i] = sat_i[i] ? MAXV : s - (MAXV + 1);
          end else if (s < 0) begin
            m_udf[i] = 1; m_q[i] = sat_i[i] ? 0 : s + (MAXV + 1);
          end else begin
            m_q[i] = s;
          end
          m_hit[i] = (m_q[i] == int'(cmp_i[i]));
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (started) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (q_o[i] !== W'(m_q[i]) || ovf_o[i] !== m_ovf[i] ||
            udf_o[i] !== m_udf[i] || hit_o[i] !== m_hit[i]) begin
          failures++;
          $display("FAIL model_cmp ch%0d t=%0t actual q=%0d ovf=%b udf=%b hit=%b expected q=%0d ovf=%b udf=%b hit=%b",
                   i, $time, q_o[i], ovf_o[i], udf_o[i], hit_o[i], m_q[i], m_ovf[i], m_udf[i], m_hit[i]);
        end
      end
`ifdef MULTI_DELTA_COUNTER_SNAPSHOT_EN
      for (int i = 0; i < N; i++) begin
        checks++;
        if (snap_o[i] !== W'(m_snap[i])) begin
          failures++;
          $display("FAIL model_snap ch%0d actual=%0d expected=%0d", i, snap_o[i], m_snap[i]);
        end
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input int exp);
    checks++;
    if (act !== W'(exp)) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Checks DUT channel and model channel against the same hand value.
  task automatic chk_ch(input string name, input int ch, input int q, input int ovf, input int udf, input int hit);
    chk({name, "_q"}, q_o[ch], q);
    chk({name, "_ovf"}, W'(ovf_o[ch]), ovf);
    chk({name, "_udf"}, W'(udf_o[ch]), udf);
    chk({name, "_hit"}, W'(hit_o[ch]), hit);
    chk({name, "_model_q"}, W'(m_q[ch]), q);
    chk({name, "_model_flags"}, W'({m_ovf[ch], m_udf[ch], m_hit[ch]}), (ovf << 2) | (udf << 1) | hit);
  endtask

  task automatic idle();
    rst_i = 0; clear_i = '0; load_i = '0; en_i = '0; down_i = '0; sat_i = '0;
    flag_clr_i = '0; delta_i = '0; d_i = '0; cmp_i = '0;
`ifdef MULTI_DELTA_COUNTER_SNAPSHOT_EN
    snap_i = 0;
`endif
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [W-1:0] r;
    idle();
    cmp_i = {N{8'hFF}};
    rst_i = 1;
    step();
    started = 1;
    rst_i = 0;
    chk_ch("reset", 0, 0, 0, 0, 0);

    en_i[0] = 1; delta_i[0] = 5;
    step(); chk_ch("up5_a", 0, 5, 0, 0, 0);
    step(); chk_ch("up5_b", 0, 10, 0, 0, 0);
    step(); chk_ch("up5_c", 0, 15, 0, 0, 0);

    en_i[0] = 0; load_i[0] = 1; d_i[0] = 250;
    step(); chk_ch("load250", 0, 250, 0, 0, 0);
    load_i[0] = 0; en_i[0] = 1; delta_i[0] = 10;
    step(); chk_ch("wrap", 0, 4, 1, 0, 0);
    en_i[0] = 0;
    step(); chk_ch("ovf_sticky", 0, 4, 1, 0, 0);
    flag_clr_i[0] = 1;
    step(); chk_ch("flag_clr", 0, 4, 0, 0, 0);
    flag_clr_i[0] = 0;

    load_i[0] = 1; d_i[0] = 3;
    step();
    load_i[0] = 0; en_i[0] = 1; down_i[0] = 1; sat_i[0] = 1; delta_i[0] = 7;
    step(); chk_ch("sat_down", 0, 0, 0, 1, 0);
    step(); chk_ch("sat_down2", 0, 0, 0, 1, 0);

    down_i[0] = 0; sat_i[0] = 0;
    clear_i[0] = 1; load_i[0] = 1; d_i[0] = 9; delta_i[0] = 1;
    step(); chk_ch("prio_clear", 0, 0, 0, 0, 0);
    clear_i[0] = 0;
    step(); chk_ch("prio_load", 0, 9, 0, 0, 0);

    en_i[0] = 0; cmp_i[0] = 20; d_i[0] = 15;
    step(); chk_ch("cmp_load", 0, 15, 0, 0, 0);
    load_i[0] = 0; en_i[0] = 1; delta_i[0] = 5;
    step(); chk_ch("cmp_hit", 0, 20, 0, 0, 1);
    en_i[0] = 0;
    step(); chk_ch("cmp_hold", 0, 20, 0, 0, 0);

    idle();
    cmp_i = {N{8'hFF}};
    clear_i[0] = 1; load_i[1] = 1; d_i[1] = 50;
    step();
    clear_i[0] = 0; load_i[1] = 0;
    en_i[0] = 1; delta_i[0] = 3;
    en_i[1] = 1; down_i[1] = 1; delta_i[1] = 2;
    step(); chk_ch("indep_up", 0, 3, 0, 0, 0); chk_ch("indep_dn", 1, 48, 0, 0, 0);
    step(); chk_ch("indep_up2", 0, 6, 0, 0, 0); chk_ch("indep_dn2", 1, 46, 0, 0, 0);
    rst_i = 1;
    step(); chk_ch("midrst0", 0, 0, 0, 0, 0); chk_ch("midrst1", 1, 0, 0, 0, 0);
    rst_i = 0;

`ifdef MULTI_DELTA_COUNTER_SNAPSHOT_EN
    en_i = '0; load_i[0] = 1; d_i[0] = 42;
    step();
    load_i[0] = 0; en_i[0] = 1; delta_i[0] = 1; snap_i = 1;
    step();
    snap_i = 0;
    chk("snap42", snap_o[0], 42); chk("snap_cnt", q_o[0], 43);
    step();
    chk("snap_hold", snap_o[0], 42); chk("snap_cnt2", q_o[0], 44);
`endif

    // Randomized traffic; the negedge compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      rst_i = ($urandom_range(0, 299) == 0);
`ifdef MULTI_DELTA_COUNTER_SNAPSHOT_EN
      snap_i = ($urandom_range(0, 7) == 0);
`endif
      for (int i = 0; i < N; i++) begin
        clear_i[i]    = ($urandom_range(0, 40) == 0);
        load_i[i]     = ($urandom_range(0, 15) == 0);
        en_i[i]       = ($urandom_range(0, 3) != 0);
        down_i[i]     = 1'($urandom);
        sat_i[i]      = 1'($urandom);
        flag_clr_i[i] = ($urandom_range(0, 12) == 0);
        r             = 8'($urandom);
        delta_i[i]    = ($urandom_range(0, 3) == 0) ? r : 8'($urandom_range(0, 8));
        d_i[i]        = 8'($urandom);
        case ($urandom_range(0, 2))
          0: cmp_i[i] = down_i[i] ? 8'(m_q[i] - int'(delta_i[i])) : 8'(m_q[i] + int'(delta_i[i]));
          1: cmp_i[i] = d_i[i];
          default: cmp_i[i] = 8'($urandom);
        endcase
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
